// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit serializer among NUM_REQ byte streams,
// with message locking (req_last low keeps the grant) and an idle-lock timeout.
// Latency: acceptance in cycle T drives tx_valid from T+1; each byte costs SEND + 1 GAP + 1 IDLE cycle.
// Backpressure: req_ready is only offered in IDLE; tx_valid is held until the serializer raises tx_ready.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_data/valid/last, req_ready   per-requester byte streams (valid/ready)
//   tx_data/valid, tx_ready          serializer hold-until-ready handshake
//   grant_id, lock_active, busy, lock_timeout   status

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int LOCK_TIMEOUT = 1000000,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic [IDW-1:0]                 grant_id,
    output logic                           lock_active,
    output logic                           busy,
    output logic                           lock_timeout
);

    // A zero timeout disables the feature; keep the counter at least one bit wide.
    localparam int             CW      = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_LAST = (LOCK_TIMEOUT > 0) ? CW'(LOCK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   to_cnt;
    logic            win_found;
    logic [IDW-1:0]  win_id;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        if (id == IDW'(NUM_REQ - 1)) return '0;
        return id + IDW'(1);
    endfunction

    // Winner selection. While locked only the owner (grant_id) is eligible.
    // Otherwise scan from rr_ptr upward; iterating from the far end down lets the
    // nearest eligible index overwrite the others.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_v;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        idx_v     = '0;
        if (lock_active) begin
            win_found = req_valid[grant_id];
            win_id    = grant_id;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                idx_v = IDW'(idx);
                if (req_valid[idx_v]) begin
                    win_found = 1'b1;
                    win_id    = idx_v;
                end
            end
        end
    end

    // Gated by rst so no transfer is signalled while the block is held in reset.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !rst) req_ready[win_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            grant_id     <= '0;
            lock_active  <= 1'b0;
            busy         <= 1'b0;
            lock_timeout <= 1'b0;
            rr_ptr       <= '0;
            to_cnt       <= '0;
        end else begin
            lock_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        tx_data  <= req_data[win_id*DATA_BITS +: DATA_BITS];
                        grant_id <= win_id;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                        to_cnt   <= '0;
                        if (req_last[win_id]) begin
                            lock_active <= 1'b0;
                            rr_ptr      <= next_id(win_id);
                        end else begin
                            lock_active <= 1'b1;
                        end
                    end else if (lock_active) begin
                        // Owner idle while holding the lock: count toward release.
                        if (LOCK_TIMEOUT != 0 && to_cnt == TO_LAST) begin
                            lock_active  <= 1'b0;
                            rr_ptr       <= next_id(grant_id);
                            lock_timeout <= 1'b1;
                            to_cnt       <= '0;
                        end else begin
                            to_cnt <= to_cnt + CW'(1);
                        end
                    end else begin
                        to_cnt <= '0;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    // One cycle of tx_valid low lets the serializer re-arm.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table vectors, directed lock/timeout/reset sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_data;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [1:0]  grant_id;
    logic        lock_active, busy, lock_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(8), .LOCK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant_id(grant_id), .lock_active(lock_active), .busy(busy), .lock_timeout(lock_timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {14'b0, req_ready, tx_valid, tx_data, grant_id, lock_active, busy, lock_timeout};
    endfunction

    // ---------------- behavioural model ----------------
    int         m_state;   // 0 idle, 1 sending, 2 gap
    logic [7:0] m_txd;
    int         m_gid, m_ptr, m_cnt;
    bit         m_lock, m_tpulse;

    task automatic model_reset();
        m_state = 0; m_txd = 8'h00; m_gid = 0; m_ptr = 0; m_cnt = 0; m_lock = 0; m_tpulse = 0;
    endtask

    function automatic int m_winner(input logic [3:0] v);
        logic [1:0] ix;
        if (m_state != 0) return -1;
        if (m_lock) begin
            ix = 2'(m_gid);
            return v[ix] ? m_gid : -1;
        end
        for (int k = 0; k < N; k++) begin
            ix = 2'((m_ptr + k) % N);
            if (v[ix]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- drive state / agents ----------------
    logic [3:0]  drv_valid, drv_last;
    logic [31:0] drv_data;
    logic        drv_txr;
    bit          agent_mode;
    int          txr_wait, send_age, stepno, pulses, tp_step;
    logic [8:0]  msg [4][16];
    int          hd[4], tl[4];
    int          grants[$];
    logic [7:0]  gdata[$];
    logic [31:0] last_act;

    task automatic model_step(input int w);
        logic [1:0] wi;
        m_tpulse = 0;
        case (m_state)
            0: if (w >= 0) begin
                   wi = 2'(w);
                   m_txd = drv_data[w*8 +: 8];
                   m_gid = w; m_state = 1; m_cnt = 0;
                   if (drv_last[wi]) begin m_lock = 0; m_ptr = (w + 1) % N; end
                   else m_lock = 1;
               end else if (m_lock) begin
                   m_cnt++;
                   if (m_cnt == TO) begin
                       m_lock = 0; m_ptr = (m_gid + 1) % N; m_tpulse = 1; m_cnt = 0;
                   end
               end
            1: if (drv_txr) m_state = 2;
            default: m_state = 0;
        endcase
        if (!m_lock) m_cnt = 0;
    endtask

    task automatic push_msg(input int r, input logic last, input logic [7:0] d);
        msg[r][tl[r]] = {last, d};
        tl[r]++;
    endtask

    task automatic step();
        int          w;
        logic [17:0] e;
        logic [3:0]  er;
        if (m_state == 1) send_age++; else send_age = 0;
        if (agent_mode) begin
            for (int i = 0; i < N; i++) begin
                if (hd[i] < tl[i]) begin
                    drv_valid[i[1:0]] = 1'b1;
                    {drv_last[i[1:0]], drv_data[i*8 +: 8]} = msg[i][hd[i]];
                end else begin
                    drv_valid[i[1:0]] = 1'b0;
                    {drv_last[i[1:0]], drv_data[i*8 +: 8]} = 9'h0;
                end
            end
            drv_txr = (send_age > txr_wait);
        end
        req_valid = drv_valid; req_data = drv_data; req_last = drv_last; tx_ready = drv_txr;
        @(negedge clk);
        w  = m_winner(drv_valid);
        er = (w >= 0) ? 4'(1 << w) : 4'b0;
        e  = {er, (m_state == 1), m_txd, 2'(m_gid), m_lock, (m_state != 0), m_tpulse};
        last_act = outs();
        check($sformatf("cycle%0d", stepno), last_act, {14'b0, e});
        for (int i = 0; i < N; i++) begin
            if (req_ready[i[1:0]] && drv_valid[i[1:0]]) begin
                grants.push_back(i);
                gdata.push_back(drv_data[i*8 +: 8]);
                if (agent_mode && hd[i] < tl[i]) hd[i]++;
            end
        end
        if (lock_timeout) begin pulses++; tp_step = stepno; end
        model_step(w);
        stepno++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_agents();
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
        grants.delete(); gdata.delete();
        pulses = 0; tp_step = -1; send_age = 0;
        drv_valid = 4'h0; drv_last = 4'h0; drv_data = 32'h0; drv_txr = 1'b0;
    endtask

    // Called at posedge+1; checks outputs while held in reset with all valids high.
    task automatic do_reset(input string name);
        rst = 1'b1;
        req_valid = 4'hF; req_last = 4'hF; req_data = 32'hFFFF_FFFF; tx_ready = 1'b1;
        @(negedge clk);
        check(name, outs(), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clear_agents();
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        txr;
        logic [17:0] e;
    } vec_t;
    vec_t tbl[15];

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic txr,
                                input logic [3:0] rdy, input logic txv, input logic [7:0] txd,
                                input logic [1:0] gid, input logic bsy);
        vec_t t;
        t.v = v; t.d = d; t.l = 4'hF; t.txr = txr;
        t.e = {rdy, txv, txd, gid, 1'b0, bsy, 1'b0};
        return t;
    endfunction

    localparam logic [31:0] D = 32'h1312_1110;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Requester 1 sends A5 alone, then all four contend: order 2,3,0,1 from rr_ptr=2.
        tbl[0]  = mk(4'b0010, 32'h0000_A500, 0, 4'b0010, 0, 8'h00, 2'd0, 0);
        tbl[1]  = mk(4'b0000, D, 0, 4'b0000, 1, 8'hA5, 2'd1, 1);
        tbl[2]  = mk(4'b0000, D, 1, 4'b0000, 1, 8'hA5, 2'd1, 1);
        tbl[3]  = mk(4'b0000, D, 1, 4'b0000, 0, 8'hA5, 2'd1, 1);
        tbl[4]  = mk(4'b1111, D, 1, 4'b0100, 0, 8'hA5, 2'd1, 0);
        tbl[5]  = mk(4'b1111, D, 0, 4'b0000, 1, 8'h12, 2'd2, 1);
        tbl[6]  = mk(4'b1111, D, 1, 4'b0000, 1, 8'h12, 2'd2, 1);
        tbl[7]  = mk(4'b1111, D, 1, 4'b0000, 0, 8'h12, 2'd2, 1);
        tbl[8]  = mk(4'b1111, D, 0, 4'b1000, 0, 8'h12, 2'd2, 0);
        tbl[9]  = mk(4'b1111, D, 1, 4'b0000, 1, 8'h13, 2'd3, 1);
        tbl[10] = mk(4'b1111, D, 0, 4'b0000, 0, 8'h13, 2'd3, 1);
        tbl[11] = mk(4'b1111, D, 0, 4'b0001, 0, 8'h13, 2'd3, 0);
        tbl[12] = mk(4'b1111, D, 1, 4'b0000, 1, 8'h10, 2'd0, 1);
        tbl[13] = mk(4'b1111, D, 0, 4'b0000, 0, 8'h10, 2'd0, 1);
        tbl[14] = mk(4'b1111, D, 0, 4'b0010, 0, 8'h10, 2'd0, 0);

        stepno = 0; agent_mode = 0; txr_wait = 0;
        model_reset(); clear_agents();
        do_reset("reset_initial");

        for (int r = 0; r < 15; r++) begin
            drv_valid = tbl[r].v; drv_data = tbl[r].d; drv_last = tbl[r].l; drv_txr = tbl[r].txr;
            step();
            check($sformatf("tbl_row%0d", r), last_act, {14'b0, tbl[r].e});
        end

        // Locked 3-byte message from requester 2 while 0 and 3 wait.
        agent_mode = 1;
        do_reset("reset_lock");
        push_msg(1, 1, 8'h55);
        run(3);
        push_msg(0, 1, 8'hA0); push_msg(3, 1, 8'hB3);
        push_msg(2, 0, 8'h21); push_msg(2, 0, 8'h22); push_msg(2, 1, 8'h23);
        run(20);
        check("lock_count", grants.size(), 6);
        if (grants.size() == 6) begin
            check("lock_ids", {grants[0][7:0], grants[1][7:0], grants[2][7:0], grants[3][7:0]}, 32'h01020202);
            check("lock_ids_tail", {grants[4][15:0], grants[5][15:0]}, 32'h0003_0000);
            check("lock_data", {gdata[1], gdata[2], gdata[3], gdata[4]}, 32'h212223B3);
        end

        // Lock held by an idle owner times out; next grant scans from 2 and wraps to 0.
        do_reset("reset_timeout");
        txr_wait = 10;
        push_msg(1, 0, 8'hA5);
        begin
            int base;
            base = stepno;
            run(1);
            push_msg(0, 1, 8'h0F);
            run(40);
            check("to_pulses", pulses, 1);
            check("to_when", tp_step - base, 33);
        end
        check("to_count", grants.size(), 2);
        if (grants.size() == 2) check("to_next", {grants[0][15:0], gdata[1], 8'h0}, 32'h0001_0F00);

        // Owner valid returns in the very cycle the timeout would fire: acceptance wins.
        do_reset("reset_race");
        txr_wait = 0;
        push_msg(0, 0, 8'hC1);
        run(22);
        push_msg(0, 1, 8'hC2);
        run(5);
        check("race_pulses", pulses, 0);
        check("race_count", grants.size(), 2);
        if (grants.size() == 2) check("race_grant", {grants[1][15:0], gdata[1], 8'h0}, 32'h0000_C200);

        // Asynchronous reset in the middle of SEND.
        do_reset("reset_pre_abort");
        txr_wait = 10;
        push_msg(2, 1, 8'h77);
        run(3);
        check("abort_pre_txv", {31'b0, tx_valid}, 32'h1);
        #2;
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check("abort_async", outs(), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset(); clear_agents();
        txr_wait = 0;
        push_msg(1, 1, 8'h11); push_msg(3, 1, 8'h33);
        run(4);
        check("abort_first", grants.size() > 0 ? grants[0] : -1, 1);

        // Randomized traffic against the model, alternating sparse/medium/dense load.
        agent_mode = 0;
        do_reset("reset_random");
        for (int blk = 0; blk < 30; blk++) begin
            int pct;
            pct = (blk % 3 == 0) ? 8 : (blk % 3 == 1) ? 45 : 95;
            for (int c = 0; c < 100; c++) begin
                for (int i = 0; i < N; i++) begin
                    drv_valid[i[1:0]] = ($urandom_range(0, 99) < pct);
                    drv_last[i[1:0]]  = ($urandom_range(0, 2) != 0);
                end
                drv_data = $urandom;
                drv_txr  = ($urandom_range(0, 2) == 0);
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
